// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one functional-unit result per cycle and drives a registered broadcast.
// Define CDB_FIXED_PRIO_EN for fixed lowest-index-wins priority; the default build is round-robin.
module cdb_arbiter #(
    parameter int                NUM_REQ     = 5,
    parameter int                TAG_W       = 5,
    parameter int                DATA_W      = 32,
    parameter logic [TAG_W-1:0]  INVALID_TAG = {TAG_W{1'b1}}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_val,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_broadcast,
    output logic [TAG_W-1:0]            out_tag,
    output logic [DATA_W-1:0]           out_val,
    output logic [2:0]                  out_src,
    output logic                        err_inv_tag
);

    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic [2:0]         grant_idx;
    logic [TAG_W-1:0]   grant_tag;
    logic [DATA_W-1:0]  grant_val;

    logic               bcast_d, bcast_q;
    logic [TAG_W-1:0]   tag_d, tag_q;
    logic [DATA_W-1:0]  val_d, val_q;
    logic [2:0]         src_d, src_q;
    logic               err_d, err_q;

`ifdef CDB_FIXED_PRIO_EN
    // Scanning downward lets the lowest valid index overwrite any higher one.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (!rst && !flush) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = 3'(i);
                end
            end
        end
    end
`else
    logic [2:0] rr_ptr_d, rr_ptr_q;

    function automatic logic [2:0] rr_index(input logic [2:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return 3'(sum);
    endfunction

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (!rst && !flush) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                if (!grant_any && req_valid[rr_index(rr_ptr_q, off)]) begin
                    grant_any = 1'b1;
                    grant_idx = rr_index(rr_ptr_q, off);
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        grant = '0;
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    assign grant_tag = req_tag[grant_idx*TAG_W +: TAG_W];
    assign grant_val = req_val[grant_idx*DATA_W +: DATA_W];
    assign req_ready = grant;

    // An invalid-tag grant is consumed but reported instead of broadcast; value and source hold.
    always_comb begin
        bcast_d = 1'b0;
        tag_d   = INVALID_TAG;
        val_d   = val_q;
        src_d   = src_q;
        err_d   = 1'b0;
        if (grant_any) begin
            if (grant_tag == INVALID_TAG) begin
                err_d = 1'b1;
            end else begin
                bcast_d = 1'b1;
                tag_d   = grant_tag;
                val_d   = grant_val;
                src_d   = grant_idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_q <= 1'b0;
            tag_q   <= INVALID_TAG;
            val_q   <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            bcast_q <= bcast_d;
            tag_q   <= tag_d;
            val_q   <= val_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end

    assign out_broadcast = bcast_q;
    assign out_tag       = tag_q;
    assign out_val       = val_q;
    assign out_src       = src_q;
    assign err_inv_tag   = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a reference model pushes expected broadcasts to a scoreboard queue.
module tb_cdb_arbiter;

    localparam int         NUM_REQ = 5;
    localparam int         TAG_W   = 5;
    localparam int         DATA_W  = 32;
    localparam logic [4:0] INV     = 5'h1F;

    typedef struct {
        logic        bcast;
        logic [4:0]  tag;
        logic [31:0] val;
        logic [2:0]  src;
        logic        err;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_val;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_broadcast;
    logic [TAG_W-1:0]          out_tag;
    logic [DATA_W-1:0]         out_val;
    logic [2:0]                out_src;
    logic                      err_inv_tag;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    int          m_ptr = 0;
    logic [31:0] m_val = '0;
    logic [2:0]  m_src = '0;

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W), .INVALID_TAG(INV)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_val(req_val),
        .req_ready(req_ready), .out_broadcast(out_broadcast), .out_tag(out_tag),
        .out_val(out_val), .out_src(out_src), .err_inv_tag(err_inv_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input logic [4:0] v, input int ptr);
`ifdef CDB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`else
        for (int off = 0; off < NUM_REQ; off++) if (v[(ptr + off) % NUM_REQ]) return (ptr + off) % NUM_REQ;
`endif
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [4:0] t, input logic [31:0] v);
        req_tag[i*TAG_W +: TAG_W]    = t;
        req_val[i*DATA_W +: DATA_W]  = v;
    endtask

    task automatic set_default_reqs();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'(8 + i), 32'hA000_0000 + 32'(i));
    endtask

    // One clock: check grant before the edge, queue the predicted broadcast, compare it after the edge.
    task automatic cycle();
        int          g;
        logic [4:0]  t;
        logic [31:0] v;
        exp_t        e;
        @(negedge clk);
        g = (rst || flush) ? -1 : model_grant(req_valid, m_ptr);
        check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        e.bcast = 1'b0; e.tag = INV; e.val = m_val; e.src = m_src; e.err = 1'b0;
        if (rst) begin
            m_ptr = 0; m_val = '0; m_src = '0;
            e.val = '0; e.src = '0;
        end else if (g >= 0) begin
            t = req_tag[g*TAG_W +: TAG_W];
            v = req_val[g*DATA_W +: DATA_W];
            m_ptr = (g == NUM_REQ - 1) ? 0 : g + 1;
            if (t == INV) begin
                e.err = 1'b1;
            end else begin
                m_val = v; m_src = 3'(g);
                e.bcast = 1'b1; e.tag = t; e.val = v; e.src = 3'(g);
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("out_broadcast", 32'(out_broadcast), 32'(e.bcast));
        check("out_tag",       32'(out_tag),       32'(e.tag));
        check("out_val",       out_val,            e.val);
        check("out_src",       32'(out_src),       32'(e.src));
        check("err_inv_tag",   32'(err_inv_tag),   32'(e.err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int exp_src;
        rst = 1'b1; flush = 1'b0; req_valid = '1;
        req_tag = '0; req_val = '0;
        set_default_reqs();

        // Reset held two cycles with every requester valid
        cycle();
        cycle();
        check("reset_tag", 32'(out_tag), 32'h1F);
        check("reset_val", out_val, 32'h0);
        rst = 1'b0;

        // Single mul request
        req_valid = 5'b00100;
        set_req(2, 5'd7, 32'hDEADBEEF);
        cycle();
        check("single_src", 32'(out_src), 32'd2);
        check("single_val", out_val, 32'hDEADBEEF);
        req_valid = '0;
        cycle();
        check("single_idle_tag", 32'(out_tag), 32'h1F);

        // Round-robin wrap from reset
        set_default_reqs();
        do_reset();
        req_valid = 5'b11111;
        for (int i = 0; i < 10; i++) begin
            cycle();
`ifdef CDB_FIXED_PRIO_EN
            exp_src = 0;
`else
            exp_src = i % NUM_REQ;
`endif
            check("rr_seq", 32'(out_src), 32'(exp_src));
        end

        // Wrap skip: walk the pointer to 4, then only add/logic valid
        do_reset();
        req_valid = 5'b01111;
        repeat (4) cycle();
        req_valid = 5'b00011;
        cycle();
        check("wrap_first", 32'(out_src), 32'd0);
        cycle();
`ifdef CDB_FIXED_PRIO_EN
        check("wrap_second", 32'(out_src), 32'd0);
`else
        check("wrap_second", 32'(out_src), 32'd1);
`endif
        req_valid = 5'b11111;
        cycle();
`ifdef CDB_FIXED_PRIO_EN
        check("wrap_ptr_end", 32'(out_src), 32'd0);
`else
        check("wrap_ptr_end", 32'(out_src), 32'd2);
`endif

        // Flush mid-stream
        do_reset();
        req_valid = 5'b11111;
        cycle();
        cycle();
        flush = 1'b1;
        cycle();
        check("flush_no_bcast", 32'(out_broadcast), 32'd0);
        flush = 1'b0;
        cycle();
`ifdef CDB_FIXED_PRIO_EN
        check("flush_resume", 32'(out_src), 32'd0);
`else
        check("flush_resume", 32'(out_src), 32'd2);
`endif

        // Invalid tag on store
        do_reset();
        req_valid = 5'b10000;
        set_req(4, INV, 32'h1234_5678);
        cycle();
        check("inv_err", 32'(err_inv_tag), 32'd1);
        check("inv_no_bcast", 32'(out_broadcast), 32'd0);
        req_valid = '0;
        cycle();
        check("inv_err_clear", 32'(err_inv_tag), 32'd0);

        // Random traffic, including mid-stream resets, flushes and stray invalid tags
        for (int n = 0; n < 300; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            req_valid = 5'($urandom);
            for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'($urandom), $urandom);
            cycle();
        end
        rst = 1'b0; flush = 1'b0; req_valid = '0;
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
